// File: rtl/move_arbiter.sv
// move_arbiter: collects player command pulses and gravity ticks into sticky
// pending bits and offers them one at a time to game control, highest
// priority first, through a valid/ready + done handshake.
module move_arbiter #(
  parameter int GRAV_BASE = 48,
  parameter int GRAV_STEP = 3,
  parameter int GRAV_MIN  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_game,
  input  logic       cmd_left,
  input  logic       cmd_right,
  input  logic       cmd_down,
  input  logic       cmd_rotate,
  input  logic       cmd_drop,
  input  logic [3:0] level,
  input  logic       game_over,
  output logic       op_valid,
  output logic [2:0] op_code,
  input  logic       op_ready,
  input  logic       op_done,
  input  logic       op_locked,
  output logic [5:0] pending
);

  // Pending bit positions; op codes are bit index + 1.
  localparam int B_LEFT   = 0;
  localparam int B_RIGHT  = 1;
  localparam int B_DOWN   = 2;
  localparam int B_ROTATE = 3;
  localparam int B_DROP   = 4;
  localparam int B_GRAV   = 5;

  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_LEFT   = 3'd1;
  localparam logic [2:0] OP_RIGHT  = 3'd2;
  localparam logic [2:0] OP_DOWN   = 3'd3;
  localparam logic [2:0] OP_ROTATE = 3'd4;
  localparam logic [2:0] OP_DROP   = 3'd5;
  localparam logic [2:0] OP_GRAV   = 3'd6;

  // Bits wiped when the piece locks: DOWN, DROP, GRAVITY.
  localparam logic [5:0] LOCK_MASK = 6'b110100;

  localparam logic [15:0] C_BASE = 16'(GRAV_BASE);
  localparam logic [15:0] C_STEP = 16'(GRAV_STEP);
  localparam logic [15:0] C_MIN  = 16'(GRAV_MIN);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_pending;
  logic [5:0]  w_pend_nxt;
  logic [15:0] r_grav_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_op_valid;
  logic [2:0]  r_op_code;
  logic        w_op_valid_nxt;
  logic [2:0]  w_op_code_nxt;

  logic [15:0] w_prod;
  logic [15:0] w_period;
  logic [15:0] w_period_m1;
  logic        w_grav_fire;
  logic        w_accept;
  logic        w_lock_clr;
  logic        w_accept_down;
  logic [5:0]  w_accept_mask;
  logic [5:0]  w_set;
  logic [5:0]  w_clr;
  logic [2:0]  w_winner;

  assign op_valid = r_op_valid;
  assign op_code  = r_op_code;
  assign pending  = r_pending;

  // Gravity period: base minus per-level step, floored at the minimum without wrapping.
  always_comb begin
    w_prod = C_STEP * {12'd0, level};
    if ((w_prod < C_BASE) && ((C_BASE - w_prod) > C_MIN)) begin
      w_period = C_BASE - w_prod;
    end else begin
      w_period = C_MIN;
    end
    if (w_period == 16'd0) begin
      w_period_m1 = 16'd0;
    end else begin
      w_period_m1 = w_period - 16'd1;
    end
  end

  // Handshake events; >= guards against a count left above the period by a level change.
  always_comb begin
    w_grav_fire   = tick_game & ~game_over & (r_grav_cnt >= w_period_m1);
    w_accept      = (r_state == S_ISSUE) & op_ready;
    w_lock_clr    = (r_state == S_WAIT_DONE) & op_done & op_locked;
    w_accept_down = w_accept & (r_op_code == OP_DOWN);
  end

  // Pending bit to drop on acceptance; granting DOWN also retires GRAVITY.
  always_comb begin
    w_accept_mask = 6'b000000;
    if (w_accept) begin
      case (r_op_code)
        OP_LEFT:   w_accept_mask = 6'b000001;
        OP_RIGHT:  w_accept_mask = 6'b000010;
        OP_DOWN:   w_accept_mask = 6'b100100;
        OP_ROTATE: w_accept_mask = 6'b001000;
        OP_DROP:   w_accept_mask = 6'b010000;
        OP_GRAV:   w_accept_mask = 6'b100000;
        default:   w_accept_mask = 6'b000000;
      endcase
    end else begin
      w_accept_mask = 6'b000000;
    end
  end

  // Pending update: sets beat clears on the same edge; game_over holds everything clear.
  always_comb begin
    w_set = 6'b000000;
    w_clr = w_accept_mask;
    if (w_lock_clr) begin
      w_clr = w_accept_mask | LOCK_MASK;
    end else begin
      w_clr = w_accept_mask;
    end
    if (game_over) begin
      w_set      = 6'b000000;
      w_pend_nxt = 6'b000000;
    end else begin
      w_set[B_LEFT]   = cmd_left & ~cmd_right;
      w_set[B_RIGHT]  = cmd_right & ~cmd_left;
      w_set[B_DOWN]   = cmd_down;
      w_set[B_ROTATE] = cmd_rotate;
      w_set[B_DROP]   = cmd_drop;
      w_set[B_GRAV]   = w_grav_fire;
      w_pend_nxt      = (r_pending & ~w_clr) | w_set;
    end
  end

  // Gravity counter: frozen in game_over, cleared by DOWN grant or lock, else counts ticks.
  always_comb begin
    w_cnt_nxt = r_grav_cnt;
    if (game_over) begin
      w_cnt_nxt = r_grav_cnt;
    end else if (w_accept_down || w_lock_clr) begin
      w_cnt_nxt = 16'd0;
    end else if (tick_game) begin
      if (w_grav_fire) begin
        w_cnt_nxt = 16'd0;
      end else begin
        w_cnt_nxt = r_grav_cnt + 16'd1;
      end
    end else begin
      w_cnt_nxt = r_grav_cnt;
    end
  end

  // Fixed priority pick: DROP > ROTATE > LEFT > RIGHT > DOWN > GRAVITY.
  always_comb begin
    w_winner = OP_NONE;
    if (r_pending[B_DROP]) begin
      w_winner = OP_DROP;
    end else if (r_pending[B_ROTATE]) begin
      w_winner = OP_ROTATE;
    end else if (r_pending[B_LEFT]) begin
      w_winner = OP_LEFT;
    end else if (r_pending[B_RIGHT]) begin
      w_winner = OP_RIGHT;
    end else if (r_pending[B_DOWN]) begin
      w_winner = OP_DOWN;
    end else if (r_pending[B_GRAV]) begin
      w_winner = OP_GRAV;
    end else begin
      w_winner = OP_NONE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if ((r_pending != 6'b000000) && !game_over) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          w_state_nxt = S_WAIT_DONE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        if (op_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered op_valid/op_code.
  always_comb begin
    w_op_valid_nxt = 1'b0;
    w_op_code_nxt  = OP_NONE;
    case (r_state)
      S_IDLE: begin
        if ((r_pending != 6'b000000) && !game_over) begin
          w_op_valid_nxt = 1'b1;
          w_op_code_nxt  = w_winner;
        end else begin
          w_op_valid_nxt = 1'b0;
          w_op_code_nxt  = OP_NONE;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          w_op_valid_nxt = 1'b0;
          w_op_code_nxt  = OP_NONE;
        end else begin
          w_op_valid_nxt = r_op_valid;
          w_op_code_nxt  = r_op_code;
        end
      end
      S_WAIT_DONE: begin
        w_op_valid_nxt = 1'b0;
        w_op_code_nxt  = OP_NONE;
      end
      default: begin
        w_op_valid_nxt = 1'b0;
        w_op_code_nxt  = OP_NONE;
      end
    endcase
  end

  // Datapath registers: outputs, pending bits and gravity counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_valid <= 1'b0;
      r_op_code  <= OP_NONE;
      r_pending  <= 6'b000000;
      r_grav_cnt <= 16'd0;
    end else begin
      r_op_valid <= w_op_valid_nxt;
      r_op_code  <= w_op_code_nxt;
      r_pending  <= w_pend_nxt;
      r_grav_cnt <= w_cnt_nxt;
    end
  end

endmodule
